// File: rtl/time_split_sequencer.sv
// Seconds-to-h:m:s converter by iterative subtraction: an hour phase, then a minute phase.
// Latency h+m+2 cycles (2..84); start is ignored while busy, out-of-range requests flag err in one cycle.
module time_split_sequencer #(
  parameter int SEC_W   = 17,
  parameter int MAX_SEC = 86399
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [SEC_W-1:0] total_sec,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [4:0]       hour,
  output logic [5:0]       minute,
  output logic [5:0]       second
);

  typedef enum logic [1:0] {IDLE, HOUR, MIN} state_t;

  localparam logic [SEC_W-1:0] MAX_V  = SEC_W'(MAX_SEC);
  localparam logic [SEC_W-1:0] SEC_HR = SEC_W'(3600);
  localparam logic [SEC_W-1:0] SEC_MN = SEC_W'(60);

  state_t           state_q, state_d;
  logic [SEC_W-1:0] rem_q, rem_d;
  logic [4:0]       hcnt_q, hcnt_d;
  logic [5:0]       mcnt_q, mcnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [4:0]       hour_q, hour_d;
  logic [5:0]       minute_q, minute_d;
  logic [5:0]       second_q, second_d;

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    hcnt_d   = hcnt_q;
    mcnt_d   = mcnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = err_q;
    hour_d   = hour_q;
    minute_d = minute_q;
    second_d = second_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (total_sec <= MAX_V) begin
            rem_d   = total_sec;
            hcnt_d  = '0;
            mcnt_d  = '0;
            err_d   = 1'b0;
            busy_d  = 1'b1;
            state_d = HOUR;
          end else begin
            // Reject without touching the previous result.
            err_d  = 1'b1;
            done_d = 1'b1;
          end
        end
      end
      HOUR: begin
        if (rem_q >= SEC_HR) begin
          rem_d  = rem_q - SEC_HR;
          hcnt_d = hcnt_q + 5'd1;
        end else begin
          state_d = MIN;
        end
      end
      MIN: begin
        if (rem_q >= SEC_MN) begin
          rem_d  = rem_q - SEC_MN;
          mcnt_d = mcnt_q + 6'd1;
        end else begin
          hour_d   = hcnt_q;
          minute_d = mcnt_q;
          second_d = rem_q[5:0];
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rem_q    <= '0;
      hcnt_q   <= '0;
      mcnt_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      hour_q   <= '0;
      minute_q <= '0;
      second_q <= '0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      hcnt_q   <= hcnt_d;
      mcnt_q   <= mcnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      hour_q   <= hour_d;
      minute_q <= minute_d;
      second_q <= second_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;
  assign hour   = hour_q;
  assign minute = minute_q;
  assign second = second_q;

endmodule

// File: tb/tb_time_split_sequencer.sv
// Directed bench for time_split_sequencer: latency, results, busy/done/err behaviour and reset abort.
module tb_time_split_sequencer;

  localparam int SEC_W = 17;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [SEC_W-1:0] total_sec = '0;
  logic             busy, done, err;
  logic [4:0]       hour;
  logic [5:0]       minute, second;

  int n_tests = 0;
  int n_fail  = 0;

  time_split_sequencer #(.SEC_W(SEC_W), .MAX_SEC(86399)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .total_sec(total_sec),
    .busy(busy), .done(done), .err(err),
    .hour(hour), .minute(minute), .second(second)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"},   32'(busy),   0);
    check({tag, "_done"},   32'(done),   0);
    check({tag, "_err"},    32'(err),    0);
    check({tag, "_hour"},   32'(hour),   0);
    check({tag, "_minute"}, 32'(minute), 0);
    check({tag, "_second"}, 32'(second), 0);
  endtask

  // Drives start for exactly one edge (edge 0); returns #1 after it.
  task automatic launch(input int sec);
    start     = 1'b1;
    total_sec = SEC_W'(sec);
    tick();
    start     = 1'b0;
  endtask

  // Counts cycles from edge 0 to done; optionally injects stray starts at cycles 5 and 40.
  task automatic wait_done(input string tag, input int exp_lat, input int eh, input int em,
                           input int es, input bit inject);
    int lat;
    int busy_cnt;
    lat = 0;
    busy_cnt = 0;
    while (done !== 1'b1 && lat < 200) begin
      if (busy === 1'b1) busy_cnt++;
      start = inject && (lat == 5 || lat == 40);
      tick();
      lat++;
    end
    start = 1'b0;
    check({tag, "_latency"},    32'(lat),      32'(exp_lat));
    check({tag, "_busy_cyc"},   32'(busy_cnt), 32'(exp_lat));
    check({tag, "_busy_done"},  32'(busy),     0);
    check({tag, "_err"},        32'(err),      0);
    check({tag, "_hour"},       32'(hour),     32'(eh));
    check({tag, "_minute"},     32'(minute),   32'(em));
    check({tag, "_second"},     32'(second),   32'(es));
  endtask

  initial begin
    int dcnt;
    #2;
    check_zero("por");
    #20 rst_n = 1'b1;
    tick();
    check_zero("idle");

    launch(0);
    wait_done("zero", 2, 0, 0, 0, 1'b0);
    tick();
    check("zero_done_width", 32'(done), 0);

    launch(3661);
    wait_done("t3661", 4, 1, 1, 1, 1'b0);
    launch(59);
    check("b2b_busy", 32'(busy), 1);
    wait_done("t59", 2, 0, 0, 59, 1'b0);
    tick();
    check("t59_done_width", 32'(done), 0);

    launch(86399);
    wait_done("max", 84, 23, 59, 59, 1'b1);
    dcnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done === 1'b1) dcnt++;
    end
    check("max_extra_done", 32'(dcnt), 0);
    check("max_busy_after", 32'(busy), 0);

    launch(3661);
    wait_done("pre_err", 4, 1, 1, 1, 1'b0);
    tick();
    launch(90000);
    check("oor_err",    32'(err),    1);
    check("oor_done",   32'(done),   1);
    check("oor_busy",   32'(busy),   0);
    check("oor_hour",   32'(hour),   1);
    check("oor_minute", 32'(minute), 1);
    check("oor_second", 32'(second), 1);
    tick();
    check("oor_done_width", 32'(done), 0);
    check("oor_err_sticky", 32'(err),  1);
    check("oor_busy_after", 32'(busy), 0);
    launch(120);
    check("err_clear", 32'(err), 0);
    wait_done("t120", 4, 0, 2, 0, 1'b0);
    tick();

    launch(86399);
    for (int i = 0; i < 10; i++) tick();
    #2 rst_n = 1'b0;
    #1 check_zero("arst");
    tick();
    tick();
    check_zero("arst_hold");
    #2 rst_n = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 90; i++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) dcnt++;
    end
    check("abort_no_done", 32'(dcnt), 0);
    check_zero("post_arst");
    launch(7200);
    wait_done("t7200", 4, 2, 0, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
